// File: rtl/i2c_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared I2C definitions: FSM state encoding, ACK/NACK levels,
//                R/W bit position and the address-match helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ADDR     = 3'd1,
      ST_ADDR_ACK = 3'd2,
      ST_WR_DATA  = 3'd3,
      ST_WR_ACK   = 3'd4,
      ST_RD_DATA  = 3'd5,
      ST_RD_ACK   = 3'd6,
      ST_IGNORE   = 3'd7
   } i2c_state_e;

   localparam logic        I2C_ACK    = 1'b0;
   localparam logic        I2C_NACK   = 1'b1;
   localparam int unsigned I2C_RW_BIT = 0;

   // True when the upper seven bits of an address byte select this target.
   function automatic logic addr_match(input logic [7:0] addr_byte,
                                       input logic [6:0] own_addr);
      return (addr_byte[7:1] == own_addr);
   endfunction

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/i2c_slave_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : i2c_slave_if
//  Description : Pad-side and client-side signal bundle of the I2C target.
//                The slave modport is the target's view; master is the view
//                of whatever drives the pads and serves the byte client.
//  Revision    : 1.0 - initial release
// ============================================================================
interface i2c_slave_if;

   logic       scl_in;
   logic       sda_in;
   logic       sda_oe;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_req;
   logic       busy;
   logic       nack_rx;

   modport slave (
      input  scl_in, sda_in, tx_data,
      output sda_oe, rx_data, rx_valid, tx_req, busy, nack_rx
   );

   modport master (
      output scl_in, sda_in, tx_data,
      input  sda_oe, rx_data, rx_valid, tx_req, busy, nack_rx
   );

endinterface : i2c_slave_if
`default_nettype wire

// File: rtl/i2c_sync_edge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : i2c_sync_edge
//  Description : Multi-flop synchronizer for one asynchronous bus line plus a
//                compare flop that yields registered single-cycle rise/fall
//                strobes. level_o changes on the same cycle as the strobe, so
//                pin-to-strobe latency is SYNC_STAGES+1 clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_LEVEL = 1'b1
) (
   input  wire logic clk,
   input  wire logic rst_,
   input  wire logic async_i,
   output logic      level_o,
   output logic      rise_o,
   output logic      fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   rise_q;
   logic                   fall_q;

   // Synchronizer chain; resets to the idle (released) bus level so that
   // leaving reset on a quiet bus produces no strobes.
   always_ff @(posedge clk) begin
      if (rst_) begin
         sync_q <= {SYNC_STAGES{RESET_LEVEL}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      end
   end

   // Compare flop and registered edge strobes, aligned with the level output.
   always_ff @(posedge clk) begin
      if (rst_) begin
         prev_q <= RESET_LEVEL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         prev_q <= sync_q[SYNC_STAGES-1];
         rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
         fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
      end
   end

   assign level_o = prev_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule : i2c_sync_edge
`default_nettype wire

// File: rtl/i2c_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : i2c_slave
//  Description : I2C target endpoint. Detects START/STOP, matches a 7-bit
//                address, receives write bytes, serves read bytes from a
//                byte client and drives SDA open-drain via sda_oe.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave
   import i2c_pkg::*;
#(
   parameter logic [6:0] ADDR        = 7'h50,
   parameter int         SYNC_STAGES = 2
) (
   input  wire logic   clk,
   input  wire logic   rst_,
   i2c_slave_if.slave  bus
);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;

   i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_scl_sync (
      .clk     (clk),
      .rst_    (rst_),
      .async_i (bus.scl_in),
      .level_o (scl_lvl),
      .rise_o  (scl_rise),
      .fall_o  (scl_fall)
   );

   i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_sda_sync (
      .clk     (clk),
      .rst_    (rst_),
      .async_i (bus.sda_in),
      .level_o (sda_lvl),
      .rise_o  (sda_rise),
      .fall_o  (sda_fall)
   );

   i2c_state_e state_q;
   logic [7:0] shift_q;
   logic [2:0] bit_cnt_q;
   logic       rw_q;
   logic       ack_on_q;   // ACK window is open (first fall seen)
   logic       ld_pend_q;  // master ACKed a read byte; load on next fall
   logic       sda_oe_q;
   logic [7:0] rx_data_q;
   logic       rx_valid_q;
   logic       busy_q;
   logic       nack_rx_q;

   logic       start_det;
   logic       stop_det;
   logic [7:0] shift_d;
   logic [2:0] bit_cnt_d;
   logic       tx_load;

   assign start_det = sda_fall & scl_lvl;
   assign stop_det  = sda_rise & scl_lvl;
   assign shift_d   = {shift_q[6:0], sda_lvl};
   assign bit_cnt_d = bit_cnt_q + 3'd1;

   // A read byte starts on the fall closing the address ACK, or on the
   // first fall after the master ACKed the previous read byte.
   assign tx_load = scl_fall & ~start_det & ~stop_det & ~rst_ &
                    (((state_q == ST_ADDR_ACK) & ack_on_q & rw_q) |
                     ((state_q == ST_RD_DATA)  & ld_pend_q));

   // Protocol FSM with shift register, bit counter and registered outputs.
   always_ff @(posedge clk) begin
      if (rst_) begin
         state_q    <= ST_IDLE;
         shift_q    <= 8'h00;
         bit_cnt_q  <= 3'd0;
         rw_q       <= 1'b0;
         ack_on_q   <= 1'b0;
         ld_pend_q  <= 1'b0;
         sda_oe_q   <= 1'b0;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         nack_rx_q  <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         nack_rx_q  <= 1'b0;
         if (start_det) begin
            // START or repeated START restarts address reception from any state.
            state_q   <= ST_ADDR;
            shift_q   <= 8'h00;
            bit_cnt_q <= 3'd0;
            ack_on_q  <= 1'b0;
            ld_pend_q <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b1;
         end else if (stop_det) begin
            // STOP abandons any partial byte without reporting it.
            state_q   <= ST_IDLE;
            shift_q   <= 8'h00;
            bit_cnt_q <= 3'd0;
            ack_on_q  <= 1'b0;
            ld_pend_q <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  sda_oe_q <= 1'b0;
               end

               ST_ADDR: begin
                  if (scl_rise) begin
                     shift_q   <= shift_d;
                     bit_cnt_q <= bit_cnt_d;
                     if (bit_cnt_q == 3'd7) begin
                        if (addr_match(shift_d, ADDR)) begin
                           rw_q    <= shift_d[I2C_RW_BIT];
                           state_q <= ST_ADDR_ACK;
                        end else begin
                           state_q <= ST_IGNORE;
                        end
                     end
                  end
               end

               ST_ADDR_ACK, ST_WR_ACK: begin
                  if (scl_fall) begin
                     if (!ack_on_q) begin
                        // Pull SDA low for the 9th clock.
                        sda_oe_q <= (I2C_ACK == 1'b0);
                        ack_on_q <= 1'b1;
                     end else begin
                        ack_on_q  <= 1'b0;
                        bit_cnt_q <= 3'd0;
                        if ((state_q == ST_ADDR_ACK) && rw_q) begin
                           sda_oe_q <= ~bus.tx_data[7];
                           shift_q  <= {bus.tx_data[6:0], 1'b0};
                           state_q  <= ST_RD_DATA;
                        end else begin
                           sda_oe_q <= 1'b0;
                           state_q  <= ST_WR_DATA;
                        end
                     end
                  end
               end

               ST_WR_DATA: begin
                  if (scl_rise) begin
                     shift_q   <= shift_d;
                     bit_cnt_q <= bit_cnt_d;
                     if (bit_cnt_q == 3'd7) begin
                        rx_data_q  <= shift_d;
                        rx_valid_q <= 1'b1;
                        state_q    <= ST_WR_ACK;
                     end
                  end
               end

               ST_RD_DATA: begin
                  if (scl_fall) begin
                     if (ld_pend_q) begin
                        sda_oe_q  <= ~bus.tx_data[7];
                        shift_q   <= {bus.tx_data[6:0], 1'b0};
                        bit_cnt_q <= 3'd0;
                        ld_pend_q <= 1'b0;
                     end else if (bit_cnt_q == 3'd7) begin
                        // Byte boundary: release SDA for the master's ACK bit.
                        sda_oe_q  <= 1'b0;
                        bit_cnt_q <= bit_cnt_d;
                        state_q   <= ST_RD_ACK;
                     end else begin
                        sda_oe_q  <= ~shift_q[7];
                        shift_q   <= {shift_q[6:0], 1'b0};
                        bit_cnt_q <= bit_cnt_d;
                     end
                  end
               end

               ST_RD_ACK: begin
                  if (scl_rise) begin
                     if (sda_lvl == I2C_ACK) begin
                        ld_pend_q <= 1'b1;
                        state_q   <= ST_RD_DATA;
                     end else begin
                        nack_rx_q <= 1'b1;
                        state_q   <= ST_IGNORE;
                     end
                  end
               end

               ST_IGNORE: begin
                  sda_oe_q <= 1'b0;
               end

               default: begin
                  state_q  <= ST_IDLE;
                  sda_oe_q <= 1'b0;
               end
            endcase
         end
      end
   end

   // SDA is released combinationally while reset is held so the bus is
   // freed in the very cycle reset is asserted.
   assign bus.sda_oe   = sda_oe_q & ~rst_;
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.tx_req   = tx_load;
   assign bus.busy     = busy_q;
   assign bus.nack_rx  = nack_rx_q;

endmodule : i2c_slave
`default_nettype wire

// File: tb/tb_i2c_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_slave
//  Description : Self-checking bench for i2c_slave: a table of byte-level bus
//                operations with expected results, plus hand-written
//                sequences for repeated START, reset during ACK and STOP
//                in the middle of a read byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave;
   import i2c_pkg::*;

   localparam int Q = 6;   // clk cycles per quarter SCL period
   localparam int K_START = 0;
   localparam int K_WR    = 1;
   localparam int K_RD    = 2;
   localparam int K_STOP  = 3;
   localparam int NV      = 14;

   typedef struct {
      int         kind;
      logic [7:0] data;      // byte written, or tx_data served and expected on read
      logic       mack;      // master ACK bit after a read byte
      logic       exp_ack;   // expected 9th-bit SDA level after a write byte
      logic       exp_rx;    // write byte should produce an rx_valid pulse
      logic       exp_busy;  // busy level after START/STOP
   } vec_t;

   logic       clk;
   logic       rst_;
   logic       m_scl;
   logic       m_sda;
   logic [7:0] tx_data_r;

   int         checks;
   int         errors;
   int         rx_cnt;
   int         txr_cnt;
   int         nack_cnt;
   int         oe_cnt;
   logic [7:0] rx_cap;

   vec_t       vec [NV];

   i2c_slave_if bus ();

   assign bus.scl_in  = m_scl;
   assign bus.sda_in  = m_sda & ~bus.sda_oe;   // open-drain wired-AND
   assign bus.tx_data = tx_data_r;

   i2c_slave #(.ADDR(7'h50), .SYNC_STAGES(2)) dut (
      .clk  (clk),
      .rst_ (rst_),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Event counters sampled mid-cycle.
   always @(negedge clk) begin
      if (bus.rx_valid) begin
         rx_cnt++;
         rx_cap = bus.rx_data;
      end
      if (bus.tx_req)  txr_cnt++;
      if (bus.nack_rx) nack_cnt++;
      if (bus.sda_oe)  oe_cnt++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One SCL clock starting from SCL low; samples the bus mid-high.
   task automatic bit_clk(input logic b, output logic samp);
      wait_clks(Q);
      m_sda = b;
      wait_clks(Q);
      m_scl = 1'b1;
      wait_clks(Q);
      samp = bus.sda_in;
      wait_clks(Q);
      m_scl = 1'b0;
   endtask

   task automatic do_start();
      m_scl = 1'b1;
      m_sda = 1'b1;
      wait_clks(2 * Q);
      m_sda = 1'b0;
      wait_clks(2 * Q);
      m_scl = 1'b0;
   endtask

   task automatic do_rstart();
      wait_clks(Q);
      m_sda = 1'b1;
      wait_clks(Q);
      m_scl = 1'b1;
      wait_clks(2 * Q);
      m_sda = 1'b0;
      wait_clks(2 * Q);
      m_scl = 1'b0;
   endtask

   task automatic do_stop();
      wait_clks(Q);
      m_sda = 1'b0;
      wait_clks(Q);
      m_scl = 1'b1;
      wait_clks(2 * Q);
      m_sda = 1'b1;
      wait_clks(2 * Q);
   endtask

   task automatic wr_byte(input logic [7:0] d, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_clk(d[i], s);
      bit_clk(1'b1, ack);
   endtask

   task automatic rd_byte(input logic mack, output logic [7:0] b);
      logic s;
      b = 8'h00;
      for (int i = 0; i < 8; i++) begin
         bit_clk(1'b1, s);
         b = {b[6:0], s};
      end
      bit_clk(mack, s);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic       ackb;
      logic       s;
      logic [7:0] rdb;
      logic [7:0] abyte;
      logic [2:0] b3;
      int         rx0, tx0, nk0, oe0, n;

      checks = 0; errors = 0;
      rx_cnt = 0; txr_cnt = 0; nack_cnt = 0; oe_cnt = 0;
      rx_cap = 8'h00;
      m_scl = 1'b1; m_sda = 1'b1; tx_data_r = 8'h00;

      //             kind     data   mack  ack   rx    busy
      vec[0]  = '{K_START, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
      vec[1]  = '{K_WR,    8'hA0, 1'b0, 1'b0, 1'b0, 1'b0};
      vec[2]  = '{K_WR,    8'h3C, 1'b0, 1'b0, 1'b1, 1'b0};
      vec[3]  = '{K_WR,    8'hC3, 1'b0, 1'b0, 1'b1, 1'b0};
      vec[4]  = '{K_STOP,  8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      vec[5]  = '{K_START, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
      vec[6]  = '{K_WR,    8'hA2, 1'b0, 1'b1, 1'b0, 1'b0};
      vec[7]  = '{K_WR,    8'h55, 1'b0, 1'b1, 1'b0, 1'b0};
      vec[8]  = '{K_STOP,  8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      vec[9]  = '{K_START, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
      vec[10] = '{K_WR,    8'hA1, 1'b0, 1'b0, 1'b0, 1'b0};
      vec[11] = '{K_RD,    8'h96, 1'b0, 1'b0, 1'b0, 1'b0};
      vec[12] = '{K_RD,    8'h5A, 1'b1, 1'b0, 1'b0, 1'b0};
      vec[13] = '{K_STOP,  8'h00, 1'b0, 1'b0, 1'b0, 1'b0};

      // Reset state
      rst_ = 1'b1;
      wait_clks(5);
      rst_ = 1'b0;
      wait_clks(2);
      chk("reset_outputs",
          {bus.sda_oe, bus.rx_valid, bus.tx_req, bus.busy, bus.nack_rx, bus.rx_data}, 0);

      // Table-driven transactions
      for (int i = 0; i < NV; i++) begin
         rx0 = rx_cnt; tx0 = txr_cnt; nk0 = nack_cnt; oe0 = oe_cnt;
         case (vec[i].kind)
            K_START: begin
               do_start();
               chk($sformatf("v%0d_busy_start", i), bus.busy, vec[i].exp_busy);
            end
            K_WR: begin
               wr_byte(vec[i].data, ackb);
               chk($sformatf("v%0d_wr_ack", i), ackb, vec[i].exp_ack);
               chk($sformatf("v%0d_wr_rx_cnt", i), rx_cnt - rx0, vec[i].exp_rx);
               if (vec[i].exp_rx)
                  chk($sformatf("v%0d_wr_rx_data", i), rx_cap, vec[i].data);
               chk($sformatf("v%0d_wr_oe_seen", i), (oe_cnt != oe0), (vec[i].exp_ack ? 0 : 1));
            end
            K_RD: begin
               tx_data_r = vec[i].data;
               rd_byte(vec[i].mack, rdb);
               chk($sformatf("v%0d_rd_data", i), rdb, vec[i].data);
               chk($sformatf("v%0d_rd_txreq", i), txr_cnt - tx0, 1);
               chk($sformatf("v%0d_rd_nack", i), nack_cnt - nk0, vec[i].mack);
            end
            default: begin
               do_stop();
               chk($sformatf("v%0d_busy_stop", i), bus.busy, vec[i].exp_busy);
            end
         endcase
      end

      // Repeated START interrupting a write byte after 4 bits
      rx0 = rx_cnt; tx0 = txr_cnt;
      do_start();
      wr_byte(8'hA0, ackb);
      chk("rs_addr_ack", ackb, 0);
      for (int i = 0; i < 4; i++) bit_clk(1'b1, s);
      do_rstart();
      tx_data_r = 8'h3C;
      wr_byte(8'hA1, ackb);
      chk("rs_readdr_ack", ackb, 0);
      rd_byte(1'b1, rdb);
      chk("rs_rd_data", rdb, 8'h3C);
      chk("rs_no_rx_valid", rx_cnt - rx0, 0);
      chk("rs_txreq", txr_cnt - tx0, 1);
      do_stop();

      // Reset asserted while the target drives the address ACK
      do_start();
      abyte = 8'hA0;
      for (int i = 7; i >= 0; i--) bit_clk(abyte[i], s);
      n = 0;
      while (!bus.sda_oe && n < 40) begin
         wait_clks(1);
         n++;
      end
      chk("rst_ack_driven", bus.sda_oe, 1);
      rst_ = 1'b1;
      #1;
      chk("rst_sda_release_now", bus.sda_oe, 0);
      wait_clks(1);
      chk("rst_outputs_mid",
          {bus.sda_oe, bus.rx_valid, bus.tx_req, bus.busy, bus.nack_rx, bus.rx_data}, 0);
      rst_ = 1'b0;
      wait_clks(Q);
      m_sda = 1'b1;
      wait_clks(Q);
      m_scl = 1'b1;
      wait_clks(2 * Q);
      rx0 = rx_cnt;
      do_start();
      chk("post_rst_busy", bus.busy, 1);
      wr_byte(8'hA0, ackb);
      chk("post_rst_addr_ack", ackb, 0);
      wr_byte(8'h11, ackb);
      chk("post_rst_data_ack", ackb, 0);
      chk("post_rst_rx_cnt", rx_cnt - rx0, 1);
      chk("post_rst_rx_data", rx_cap, 8'h11);
      do_stop();
      chk("post_rst_busy_stop", bus.busy, 0);

      // STOP in the middle of a read byte
      tx_data_r = 8'h96;
      do_start();
      wr_byte(8'hA1, ackb);
      chk("sr_addr_ack", ackb, 0);
      b3 = 3'b000;
      for (int i = 0; i < 3; i++) begin
         bit_clk(1'b1, s);
         b3 = {b3[1:0], s};
      end
      chk("sr_partial_bits", b3, 3'b100);
      nk0 = nack_cnt;
      do_stop();
      chk("sr_sda_released", bus.sda_oe, 0);
      chk("sr_busy", bus.busy, 0);
      chk("sr_no_nack", nack_cnt - nk0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_i2c_slave
`default_nettype wire
